// File: rtl/sr_cpu_shared_im.sv
`timescale 1ns/1ps
// sr_cpu_shared_im: multi-cycle RV32I-subset CPU fetching from an arbitrated shared instruction memory.
// Define SR_CPU_RETIRE_CNT_EN to build the retired-instruction counter; otherwise retired is tied to 0.
module sr_cpu_shared_im #(
    parameter logic [31:0] RST_PC   = 32'h0000_0000,
    parameter int          RF_DEPTH = 32,
    parameter int          IM_AW    = 10,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imReq,
    output logic [IM_AW-1:0] imAddr,
    input  logic             imGnt,
    input  logic [31:0]      imData,
    input  logic             imDataVld,
    input  logic [4:0]       regAddr,
    output logic [31:0]      regData,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    localparam int         RF_AW  = $clog2(RF_DEPTH);
    localparam logic [5:0] RF_LIM = 6'(RF_DEPTH);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        halted_q, halted_d;
    logic [31:0] rf [RF_DEPTH];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_b, imm_u;
    logic [31:0] rs1_val, rs2_val, wr_data;
    logic        use_rd, use_rs1, use_rs2;
    logic        is_branch, br_taken, legal, rf_we;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u  = {ir_q[31:12], 12'h000};

    function automatic logic idx_ok(input logic [4:0] idx);
        return {1'b0, idx} < RF_LIM;
    endfunction

    // x0 and out-of-range indices read as zero; rf[0] is never written.
    always_comb begin
        rs1_val = '0;
        if (rs1 != 5'd0 && idx_ok(rs1)) begin
            rs1_val = rf[rs1[RF_AW-1:0]];
        end
    end

    always_comb begin
        rs2_val = '0;
        if (rs2 != 5'd0 && idx_ok(rs2)) begin
            rs2_val = rf[rs2[RF_AW-1:0]];
        end
    end

    always_comb begin
        regData = '0;
        if (regAddr == 5'd0) begin
            regData = pc_q;
        end else if (idx_ok(regAddr)) begin
            regData = rf[regAddr[RF_AW-1:0]];
        end
    end

    always_comb begin
        legal     = 1'b0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_branch = 1'b0;
        br_taken  = 1'b0;
        wr_data   = '0;
        case (opcode)
            7'b0110111: begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                wr_data = imm_u;
            end
            7'b0010011: begin
                legal   = (funct3 == 3'b000);
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                wr_data = rs1_val + imm_i;
            end
            7'b0110011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: begin legal = 1'b1; wr_data = rs1_val + rs2_val; end
                    {7'h20, 3'b000}: begin legal = 1'b1; wr_data = rs1_val - rs2_val; end
                    {7'h00, 3'b110}: begin legal = 1'b1; wr_data = rs1_val | rs2_val; end
                    {7'h00, 3'b101}: begin legal = 1'b1; wr_data = rs1_val >> rs2_val[4:0]; end
                    {7'h00, 3'b011}: begin legal = 1'b1; wr_data = {31'b0, rs1_val < rs2_val}; end
                    default: legal = 1'b0;
                endcase
            end
            7'b1100011: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                is_branch = 1'b1;
                if (funct3 == 3'b000) begin
                    legal    = 1'b1;
                    br_taken = (rs1_val == rs2_val);
                end else if (funct3 == 3'b001) begin
                    legal    = 1'b1;
                    br_taken = (rs1_val != rs2_val);
                end
            end
            default: legal = 1'b0;
        endcase
        // Touching a register the file does not have is treated like an illegal opcode.
        if ((use_rd && !idx_ok(rd)) || (use_rs1 && !idx_ok(rs1)) || (use_rs2 && !idx_ok(rs2))) begin
            legal = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        rf_we    = 1'b0;
        case (state_q)
            FETCH: begin
                if (imGnt) begin
                    if (imDataVld) begin
                        ir_d    = imData;
                        state_d = EXEC;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imDataVld) begin
                    ir_d    = imData;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (legal) begin
                    rf_we   = use_rd && (rd != 5'd0);
                    pc_d    = (is_branch && br_taken) ? pc_q + imm_b : pc_q + 32'd4;
                    state_d = FETCH;
                end else begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FETCH;
            pc_q     <= RST_PC;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    // Register file deliberately has no reset.
    always_ff @(posedge clk) begin
        if (rf_we) begin
            rf[rd[RF_AW-1:0]] <= wr_data;
        end
    end

    // Request is masked by reset so an abandoned fetch never shows on the arbiter.
    assign imReq  = rst && (state_q == FETCH);
    assign imAddr = pc_q[IM_AW+1:2];
    assign halted = halted_q;

`ifdef SR_CPU_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             ret_inc;

    assign ret_inc = (state_q == EXEC) && legal;

    always_comb begin
        retired_d = retired_q;
        if (ret_inc) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_sr_cpu_shared_im.sv
`timescale 1ns/1ps
// Testbench for sr_cpu_shared_im: directed and random programs checked against an instruction-level model.
module tb_sr_cpu_shared_im;
    localparam logic [31:0] RST_PC_B = 32'h0000_0100;
`ifdef SR_CPU_RETIRE_CNT_EN
    localparam logic [31:0] EXP_RET2 = 32'd2;
    localparam logic [31:0] EXP_WRAP = 32'd1;
`else
    localparam logic [31:0] EXP_RET2 = 32'd0;
    localparam logic [31:0] EXP_WRAP = 32'd0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, gnt, vld, sel;
    logic [31:0] im_data;
    logic [4:0]  reg_addr;
    logic        req_a, req_b, halted_a, halted_b;
    logic [9:0]  addr_a, addr_b;
    logic [31:0] rdata_a, rdata_b;
    logic [15:0] ret_a;
    logic [1:0]  ret_b;
    logic        req, hlt;
    logic [9:0]  addr;
    logic [31:0] rdata, ret;

    assign req   = sel ? req_b : req_a;
    assign hlt   = sel ? halted_b : halted_a;
    assign addr  = sel ? addr_b : addr_a;
    assign rdata = sel ? rdata_b : rdata_a;
    assign ret   = sel ? {30'b0, ret_b} : {16'b0, ret_a};

    sr_cpu_shared_im #(.RST_PC(32'h0), .RF_DEPTH(32), .IM_AW(10), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .imReq(req_a), .imAddr(addr_a), .imGnt(gnt & ~sel),
        .imData(im_data), .imDataVld(vld & ~sel), .regAddr(reg_addr), .regData(rdata_a),
        .halted(halted_a), .retired(ret_a));

    sr_cpu_shared_im #(.RST_PC(RST_PC_B), .RF_DEPTH(16), .IM_AW(10), .CNT_W(2)) dut_sr_cpu_shared_im (
        .clk(clk), .rst(rst), .imReq(req_b), .imAddr(addr_b), .imGnt(gnt & sel),
        .imData(im_data), .imDataVld(vld & sel), .regAddr(reg_addr), .regData(rdata_b),
        .halted(halted_b), .retired(ret_b));

    // Instruction-level model state
    logic [31:0] mem [1024];
    logic [31:0] m_rf [32];
    logic [31:0] m_pc;
    int unsigned m_ret;
    bit          m_halt;
    int          depth, cnt_w;
    int          tests_run = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_ret();
`ifdef SR_CPU_RETIRE_CNT_EN
        return 32'(m_ret % (32'd1 << cnt_w));
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                          input int off);
        logic [12:0] o;
        o = 13'(off);
        return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] rand_instr(input int maxreg);
        int          k;
        int          off;
        logic [4:0]  r0, r1, r2;
        k   = int'($urandom_range(0, 8));
        r0  = 5'($urandom_range(0, maxreg - 1));
        r1  = 5'($urandom_range(0, maxreg - 1));
        r2  = 5'($urandom_range(0, maxreg - 1));
        off = (int'($urandom_range(0, 32)) - 16) * 4;
        case (k)
            0: return enc_u(r0, 20'($urandom));
            1: return enc_i(r0, r1, 12'($urandom));
            2: return enc_r(7'h00, 3'b000, r0, r1, r2);
            3: return enc_r(7'h20, 3'b000, r0, r1, r2);
            4: return enc_r(7'h00, 3'b110, r0, r1, r2);
            5: return enc_r(7'h00, 3'b101, r0, r1, r2);
            6: return enc_r(7'h00, 3'b011, r0, r1, r2);
            7: return enc_b(3'b000, r1, r2, off);
            default: return enc_b(3'b001, r1, r2, off);
        endcase
    endfunction

    // Architectural effect of one instruction.
    task automatic model_exec(input logic [31:0] ins, output bit wrote, output logic [4:0] rd);
        logic [4:0]  rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b, res, nxt, imm_i, imm_b;
        bit          ok, n_rd, n_rs1, n_rs2;
        rd    = ins[11:7];
        rs1   = ins[19:15];
        rs2   = ins[24:20];
        f3    = ins[14:12];
        f7    = ins[31:25];
        a     = (rs1 == 0) ? 32'd0 : m_rf[rs1];
        b     = (rs2 == 0) ? 32'd0 : m_rf[rs2];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ok = 1; n_rd = 0; n_rs1 = 0; n_rs2 = 0;
        res = 0;
        nxt = m_pc + 32'd4;
        case (ins[6:0])
            7'h37: begin n_rd = 1; res = {ins[31:12], 12'h000}; end
            7'h13: begin n_rd = 1; n_rs1 = 1; ok = (f3 == 0); res = a + imm_i; end
            7'h33: begin
                n_rd = 1; n_rs1 = 1; n_rs2 = 1;
                if (f7 == 7'h00 && f3 == 3'd0) res = a + b;
                else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
                else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
                else if (f7 == 7'h00 && f3 == 3'd5) res = a >> b[4:0];
                else if (f7 == 7'h00 && f3 == 3'd3) res = (a < b) ? 32'd1 : 32'd0;
                else ok = 0;
            end
            7'h63: begin
                n_rs1 = 1; n_rs2 = 1;
                if (f3 == 3'd0) begin
                    if (a == b) nxt = m_pc + imm_b;
                end else if (f3 == 3'd1) begin
                    if (a != b) nxt = m_pc + imm_b;
                end else ok = 0;
            end
            default: ok = 0;
        endcase
        if ((n_rd && rd >= depth) || (n_rs1 && rs1 >= depth) || (n_rs2 && rs2 >= depth)) ok = 0;
        wrote = 0;
        if (!ok) begin
            m_halt = 1;
        end else begin
            if (n_rd && rd != 0) begin
                m_rf[rd] = res;
                wrote = 1;
            end
            m_pc = nxt;
            m_ret++;
        end
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
        reg_addr = a;
        #1;
        v = rdata;
    endtask

    // Serve one fetch of the selected CPU, then check its architectural state against the model.
    task automatic fetch_exec(input int gdly, input int vdly, input bit spur);
        logic [9:0]  a0;
        logic [31:0] ins, v;
        logic [4:0]  rd;
        bit          wrote;
        int          n;
        n = 0;
        while (req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req", 32'(req), 1);
        a0 = addr;
        check("fetch_addr", 32'(a0), 32'(m_pc[11:2]));
        for (int i = 0; i < gdly; i++) begin
            vld     = spur && ($urandom_range(0, 1) == 1);
            im_data = 32'h0000_0073;
            @(negedge clk);
            check("hold_req", 32'(req), 1);
            check("hold_addr", 32'(addr), 32'(a0));
        end
        ins     = mem[a0];
        gnt     = 1'b1;
        im_data = ins;
        vld     = (vdly == 0);
        @(negedge clk);
        gnt = 1'b0;
        vld = 1'b0;
        if (vdly > 0) begin
            check("wait_req", 32'(req), 0);
            for (int i = 0; i < vdly - 1; i++) @(negedge clk);
            im_data = ins;
            vld     = 1'b1;
            @(negedge clk);
            vld = 1'b0;
        end
        check("exec_req", 32'(req), 0);
        vld     = spur && ($urandom_range(0, 1) == 1);
        im_data = 32'h0000_0073;
        @(negedge clk);
        vld = 1'b0;
        model_exec(ins, wrote, rd);
        check("halted", 32'(hlt), 32'(m_halt));
        check("next_req", 32'(req), m_halt ? 32'd0 : 32'd1);
        check("retired", ret, exp_ret());
        rd_reg(5'd0, v);
        check("pc", v, m_pc);
        if (wrote) begin
            rd_reg(rd, v);
            check("rd_val", v, m_rf[rd]);
        end
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) begin
            if (!m_halt) begin
                fetch_exec(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            end
        end
    endtask

    task automatic fill_random(input int maxreg);
        for (int i = 0; i < 1024; i++) mem[i] = rand_instr(maxreg);
    endtask

    task automatic load_prelude();
        logic [9:0] idx;
        for (int r = 1; r < depth; r++) begin
            idx = m_pc[11:2] + 10'(r - 1);
            mem[idx] = enc_i(5'(r), 5'd0, 12'($urandom));
        end
    endtask

    task automatic do_reset();
        logic [31:0] v;
        gnt = 1'b0;
        vld = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_req", 32'(req), 0);
        check("rst_halted", 32'(hlt), 0);
        check("rst_retired", ret, 0);
        rd_reg(5'd0, v);
        check("rst_pc", v, sel ? RST_PC_B : 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_pc   = sel ? RST_PC_B : 32'h0;
        m_ret  = 0;
        m_halt = 0;
        depth  = sel ? 16 : 32;
        cnt_w  = sel ? 2 : 16;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        rst = 1'b1; gnt = 1'b0; vld = 1'b0; sel = 1'b0; im_data = '0; reg_addr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        @(negedge clk);
        do_reset();

        // Two addi instructions, grant and valid one cycle apart
        mem[0] = enc_i(5'd1, 5'd0, 12'd5);
        mem[1] = enc_i(5'd2, 5'd1, 12'd3);
        mem[2] = enc_b(3'b000, 5'd0, 5'd0, -4);
        fetch_exec(0, 1, 0);
        fetch_exec(0, 1, 0);
        rd_reg(5'd2, v);  check("addi_x2", v, 32'd8);
        rd_reg(5'd1, v);  check("addi_x1", v, 32'd5);
        check("addi_retired", ret, EXP_RET2);
        rd_reg(5'd0, v);  check("addi_pc", v, 32'd8);

        // Long grant stall, then taken beq back to 4
        fetch_exec(10, 1, 1);
        rd_reg(5'd0, v);  check("beq_pc", v, 32'd4);
        // Same-cycle grant and valid, not-taken bne
        mem[1] = enc_b(3'b001, 5'd0, 5'd0, 8);
        fetch_exec(0, 0, 0);
        rd_reg(5'd0, v);  check("bne_pc", v, 32'd8);

        // Reset while waiting for data; the stale valid must be ignored
        gnt = 1'b1; im_data = 32'h0000_0073;
        @(negedge clk);
        gnt = 1'b0;
        check("midfetch_wait_req", 32'(req), 0);
        do_reset();
        vld = 1'b1; im_data = 32'h0000_0073;
        @(negedge clk);
        vld = 1'b0;
        check("stale_vld_halted", 32'(hlt), 0);
        check("stale_vld_req", 32'(req), 1);
        rd_reg(5'd0, v);  check("stale_vld_pc", v, 32'd0);

        // Random program on the 32-register core
        fill_random(32);
        load_prelude();
        run_n(31);
        run_n(150);

        // ecall halts and freezes everything
        mem[m_pc[11:2]] = 32'h0000_0073;
        fetch_exec(1, 1, 0);
        check("ecall_halted", 32'(hlt), 1);
        for (int i = 0; i < 6; i++) begin
            gnt = 1'b1; vld = 1'b1; im_data = enc_i(5'd1, 5'd0, 12'd1);
            @(negedge clk);
            check("freeze_req", 32'(req), 0);
            check("freeze_halted", 32'(hlt), 1);
            check("freeze_retired", ret, exp_ret());
            rd_reg(5'd0, v);  check("freeze_pc", v, m_pc);
        end
        gnt = 1'b0; vld = 1'b0;

        // 16-register core with a 2-bit counter
        sel = 1'b1;
        do_reset();
        fill_random(16);
        load_prelude();
        run_n(5);
        check("wrap5_retired", ret, EXP_WRAP);
        run_n(10);
        run_n(40);
        mem[m_pc[11:2]] = enc_r(7'h00, 3'b000, 5'd20, 5'd1, 5'd2);
        fetch_exec(0, 1, 0);
        check("x20_halted", 32'(hlt), 1);
        check("x20_req", 32'(req), 0);
        rd_reg(5'd0, v);   check("x20_pc", v, m_pc);
        rd_reg(5'd20, v);  check("x20_regdata", v, 32'd0);
        do_reset();
        check("post_rst_halted", 32'(hlt), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
